// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, the halt encoding and fetch states.
package cpu_pkg;
  localparam int ADDR_W = 8;
  localparam int INSTR_W = 16;
  localparam logic [INSTR_W-1:0] HALT_INSTR = 16'h0000;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;
endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: drives the ROM from pc, holds one instruction in ir for
// decode with a valid/ready handshake, honours branch redirects and a halt word.
module fetch_unit #(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [INSTR_W-1:0] HALT_INSTR = cpu_pkg::HALT_INSTR
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_instr,
  output logic [INSTR_W-1:0] ir,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic               ir_valid,
  input  logic               ir_ready,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  output logic               halted,
  output logic [15:0]        instr_count
);
  import cpu_pkg::*;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_pc, w_pc_nxt;
  logic [INSTR_W-1:0]  r_ir, w_ir_nxt;
  logic [ADDR_W-1:0]   r_ir_pc, w_ir_pc_nxt;
  logic                r_ir_valid, w_ir_valid_nxt;
  logic [15:0]         r_cnt;
  logic                w_load;
  logic                w_deliver;

  assign w_load    = (r_state == RUN) && !br_taken && (!r_ir_valid || ir_ready);
  // A word handed over in the same cycle as a redirect is squashed, not counted.
  assign w_deliver = r_ir_valid && ir_ready && !br_taken;

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_ir_nxt       = r_ir;
    w_ir_pc_nxt    = r_ir_pc;
    w_ir_valid_nxt = r_ir_valid;
    if (br_taken) begin
      w_state_nxt    = RUN;
      w_pc_nxt       = br_target;
      w_ir_valid_nxt = 1'b0;
    end else if (w_load) begin
      if (rom_instr == HALT_INSTR) begin
        w_state_nxt    = HALTED;
        w_ir_valid_nxt = 1'b0;
      end else begin
        w_ir_nxt       = rom_instr;
        w_ir_pc_nxt    = r_pc;
        w_ir_valid_nxt = 1'b1;
        w_pc_nxt       = r_pc + PC_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RUN;
      r_pc       <= RESET_PC;
      r_ir       <= '0;
      r_ir_pc    <= '0;
      r_ir_valid <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_ir       <= w_ir_nxt;
      r_ir_pc    <= w_ir_pc_nxt;
      r_ir_valid <= w_ir_valid_nxt;
      if (w_deliver && (r_cnt != 16'hFFFF))
        r_cnt <= r_cnt + 16'd1;
    end
  end

  assign rom_addr    = r_pc;
  assign ir          = r_ir;
  assign ir_pc       = r_ir_pc;
  assign ir_valid    = r_ir_valid;
  assign halted      = (r_state == HALTED);
  assign instr_count = r_cnt;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized checks of fetch_unit against a behavioural model
// of the fetch rules, driven by a small ROM stub.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rom_addr;
  logic [15:0] rom_instr;
  logic [15:0] ir;
  logic [7:0]  ir_pc;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic        br_taken = 1'b0;
  logic [7:0]  br_target = 8'h00;
  logic        halted;
  logic [15:0] instr_count;

  int checks = 0;
  int errors = 0;

  // reference state
  logic [7:0]  m_pc;
  logic [15:0] m_ir;
  logic [7:0]  m_ir_pc;
  logic        m_valid;
  logic        m_halt;
  logic [15:0] m_cnt;

  fetch_unit dut (
    .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_instr(rom_instr),
    .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .br_taken(br_taken), .br_target(br_target), .halted(halted),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_f(input logic [7:0] a);
    logic [15:0] pat [4];
    pat[0] = 16'h0012; pat[1] = 16'h0043; pat[2] = 16'h0067; pat[3] = 16'h0098;
    if (a <= 8'h0B) return pat[a % 4];
    if (a == 8'hFF) return 16'h1234;
    return 16'h0000;
  endfunction

  assign rom_instr = rom_f(rom_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_edge(input logic r, input logic rdy, input logic br,
                                     input logic [7:0] tgt);
    logic [15:0] w;
    if (r) begin
      m_pc = 8'h00; m_ir = 16'h0; m_ir_pc = 8'h00;
      m_valid = 1'b0; m_halt = 1'b0; m_cnt = 16'h0;
      return;
    end
    if (m_valid && rdy && !br && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    if (br) begin
      m_pc = tgt; m_valid = 1'b0; m_halt = 1'b0;
    end else if (!m_halt && (!m_valid || rdy)) begin
      w = rom_f(m_pc);
      if (w == 16'h0000) begin
        m_halt = 1'b1; m_valid = 1'b0;
      end else begin
        m_ir = w; m_ir_pc = m_pc; m_valid = 1'b1;
        m_pc = 8'((int'(m_pc) + 1) % 256);
      end
    end
  endfunction

  // Drive one cycle of inputs, advance model and DUT, compare all outputs.
  task automatic step(input logic r, input logic rdy, input logic br, input logic [7:0] tgt);
    rst = r; ir_ready = rdy; br_taken = br; br_target = tgt;
    @(posedge clk);
    model_edge(r, rdy, br, tgt);
    #1;
    check("rom_addr", 32'(rom_addr), 32'(m_pc));
    check("ir_valid", 32'(ir_valid), 32'(m_valid));
    check("halted", 32'(halted), 32'(m_halt));
    check("instr_count", 32'(instr_count), 32'(m_cnt));
    check("ir", 32'(ir), 32'(m_ir));
    check("ir_pc", 32'(ir_pc), 32'(m_ir_pc));
  endtask

  initial begin
    logic [15:0] pat [4];
    logic [15:0] cnt_before;
    logic [7:0]  tgts [6];
    pat[0] = 16'h0012; pat[1] = 16'h0043; pat[2] = 16'h0067; pat[3] = 16'h0098;
    tgts[0] = 8'h00; tgts[1] = 8'h04; tgts[2] = 8'h09;
    tgts[3] = 8'h0B; tgts[4] = 8'hFE; tgts[5] = 8'hFF;

    // reset state
    step(1'b1, 1'b1, 1'b1, 8'h33);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    check("rst_pc", 32'(rom_addr), 32'h00);
    check("rst_valid", 32'(ir_valid), 32'h0);
    check("rst_cnt", 32'(instr_count), 32'h0);
    check("rst_ir", 32'(ir), 32'h0);

    // straight-line fetch, one per cycle, ending in halt at 0x0C
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00);
      check("seq_ir", 32'(ir), 32'(pat[k % 4]));
      check("seq_ir_pc", 32'(ir_pc), 32'(k));
      check("seq_valid", 32'(ir_valid), 32'h1);
    end
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check("halt_flag", 32'(halted), 32'h1);
    check("halt_pc", 32'(rom_addr), 32'h0C);
    check("halt_cnt", 32'(instr_count), 32'd12);
    check("halt_valid", 32'(ir_valid), 32'h0);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check("halt_hold_pc", 32'(rom_addr), 32'h0C);

    // redirect out of HALTED
    step(1'b0, 1'b1, 1'b1, 8'h04);
    check("unhalt", 32'(halted), 32'h0);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check("unhalt_ir", 32'(ir), 32'h0012);
    check("unhalt_ir_pc", 32'(ir_pc), 32'h04);

    // stall while ir=0043 from 0x01
    step(1'b0, 1'b1, 1'b1, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check("pre_stall_ir", 32'(ir), 32'h0043);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b0, 8'h00);
      check("stall_ir", 32'(ir), 32'h0043);
      check("stall_ir_pc", 32'(ir_pc), 32'h01);
      check("stall_pc", 32'(rom_addr), 32'h02);
    end
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check("post_stall_ir", 32'(ir), 32'h0067);
    check("post_stall_ir_pc", 32'(ir_pc), 32'h02);

    // redirect with a delivery in the same cycle: squashed, not counted
    cnt_before = instr_count;
    step(1'b0, 1'b1, 1'b1, 8'h08);
    check("br_nocount", 32'(instr_count), 32'(cnt_before));
    check("br_valid", 32'(ir_valid), 32'h0);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check("br_ir", 32'(ir), 32'h0012);
    check("br_ir_pc", 32'(ir_pc), 32'h08);

    // pc wrap at 0xFF
    step(1'b0, 1'b1, 1'b1, 8'hFF);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check("wrap_ir", 32'(ir), 32'h1234);
    check("wrap_ir_pc", 32'(ir_pc), 32'hFF);
    check("wrap_pc", 32'(rom_addr), 32'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check("wrap_next_ir", 32'(ir), 32'h0012);
    check("wrap_next_ir_pc", 32'(ir_pc), 32'h00);

    // reset mid-stall at pc=0x06
    step(1'b0, 1'b1, 1'b1, 8'h05);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check("pre_rst_pc", 32'(rom_addr), 32'h06);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    check("midrst_valid", 32'(ir_valid), 32'h0);
    check("midrst_cnt", 32'(instr_count), 32'h0);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check("after_rst_ir", 32'(ir), 32'h0012);
    check("after_rst_ir_pc", 32'(ir_pc), 32'h00);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 49) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 9) == 0),
           tgts[$urandom_range(0, 5)]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning program-counter and ROM address width.
REQ-002 SHALL have parameter INSTR_W, default 16, meaning instruction width.
REQ-003 SHALL have parameter RESET_PC, default 8'h00, meaning PC value after reset.
REQ-004 SHALL have parameter HALT_INSTR, default 16'h0000, meaning the instruction word that stops fetch; it matches the ROM's default output.
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1, the reset; reset is synchronous and active-high.
REQ-007 SHALL have port rom_addr, output, ADDR_W, the address driven to the instruction ROM.
REQ-008 SHALL have port rom_instr, input, INSTR_W, the ROM data, combinational from rom_addr in the same cycle.
REQ-009 SHALL have port ir, output, INSTR_W, the instruction register presented to decode.
REQ-010 SHALL have port ir_pc, output, ADDR_W, the address the ir word was fetched from.
REQ-011 SHALL have port ir_valid, output, 1, meaning ir holds an undelivered instruction.
REQ-012 SHALL have port ir_ready, input, 1, meaning decode accepts ir this cycle.
REQ-013 SHALL have port br_taken, input, 1, the redirect request.
REQ-014 SHALL have port br_target, input, ADDR_W, the redirect address.
REQ-015 SHALL have port halted, output, 1, high while in HALTED.
REQ-016 SHALL have port instr_count, output, 16, the count of delivered instructions.

Function
REQ-017 SHALL drive rom_addr = pc combinationally at all times.
REQ-018 SHALL implement states RUN and HALTED; halted = (state == HALTED).
REQ-019 SHALL define a delivery as ir_valid && ir_ready at a clock edge.
REQ-020 SHALL define the load condition as RUN && !br_taken && (!ir_valid || ir_ready).
REQ-021 On load with rom_instr != HALT_INSTR, SHALL set ir <= rom_instr, ir_pc <= pc, ir_valid <= 1, and pc <= pc + 1 modulo 2^ADDR_W (8'hFF wraps to 8'h00).
REQ-022 On load with rom_instr == HALT_INSTR, SHALL go to HALTED, clear ir_valid, and hold pc; the halt word is never presented on ir.
REQ-023 When RUN && ir_valid && !ir_ready && !br_taken, SHALL hold pc, ir, ir_pc and ir_valid unchanged.
REQ-024 br_taken SHALL take priority over load, stall and HALTED: pc <= br_target, ir_valid <= 0 (a pending ir is discarded even if ir_ready), state <= RUN.
REQ-025 Redirect latency: with br_taken at edge n, the target instruction SHALL be valid on ir after edge n+1.
REQ-026 In HALTED without br_taken, SHALL hold pc and keep ir_valid = 0.
REQ-027 Steady-state throughput with ir_ready held high SHALL be one instruction per cycle.
REQ-028 instr_count SHALL increment by 1 on each delivery and saturate at 16'hFFFF.
REQ-029 A delivery coinciding with br_taken SHALL NOT be counted.

Reset
REQ-030 While rst is high at an edge, SHALL set pc = RESET_PC, ir = 0, ir_pc = 0, ir_valid = 0, instr_count = 0 and state = RUN, overriding all other inputs.
REQ-031 Reset asserted mid-stall or mid-redirect SHALL discard the pending instruction; fetch SHALL restart at RESET_PC on the first edge after rst falls.

Structure
REQ-032 A shared cpu package SHALL hold ADDR_W, INSTR_W, HALT_INSTR and the RUN/HALTED state encoding.
REQ-033 The block SHALL be a single module with no sub-modules; the ROM is instantiated beside it at CPU top level.

Verification (ROM: 0x00-0x0B = 12,43,67,98 repeating; default 0000)
REQ-034 Reset release, ir_ready=1 -> ir sequence 0012,0043,0067,0098,... with ir_pc 00..0B, one per cycle; fetch from 0x0C gives halted=1, pc=0C, instr_count=12.
REQ-035 ir_ready=0 for 3 cycles while ir=0043 -> ir, ir_pc=01 and pc=02 held; no duplicate or skipped word after ir_ready rises.
REQ-036 br_taken, target 0x08, asserted while ir_valid=1 and ir_ready=1 -> that word is not counted; next ir=0012 with ir_pc=08 two edges later.
REQ-037 In HALTED, br_taken to 0x04 -> halted=0; ir=0012, ir_pc=04 follows.
REQ-038 Redirect to 0xFF, with the ROM stub returning 0x1234 there -> ir_pc=FF is delivered, then pc=00 and ir=0012.
REQ-039 rst pulsed one cycle mid-stall at pc=0x06 -> all outputs reset; first ir after release is 0012 with ir_pc=00.
